// File: rtl/regfile_alu_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_alu_sequencer
//
// Multi-cycle controller that owns a dual-read / single-write register file
// and an external combinational ALU. It takes one register-to-register
// instruction at a time and runs it through READ -> EXEC -> WB. The single
// register-file write port is shared with an external load port. Instruction
// writeback wins over loads.
//
// Handshake: an instruction transfers on a rising Clock edge where both
// Instr_Valid and Instr_Ready are high. Instr_Ready is high only in IDLE.
// Loads use a level request: Load_Req is held, together with Load_Addr and
// Load_Data, until the requester sees Load_Ack. Every cycle with Load_Ack high
// writes the register file at the next edge.
//
// Ports:
//   Clock, Reset_n              clock; asynchronous active-low reset
//   Instr_Valid / Instr_Ready   instruction handshake
//   Instr_Opcode/Rd/Rs1/Rs2     instruction fields (opcode 0 is a NOP)
//   Done                        one-cycle retire pulse
//   Busy                        high whenever the FSM is not in IDLE
//   Load_Req/Addr/Data, Load_Ack  external write port with acknowledge
//   Read_Addr_1/2, Data_Out_1/2 register-file read ports (asynchronous read)
//   Write_Addr, Data_In, Write_enable  register-file write port
//   ALU_Opcode, ALU_A, ALU_B, ALU_Result  external ALU interface
//   Dbg_State                   current FSM state, for observation only
// -----------------------------------------------------------------------------
module regfile_alu_sequencer #(
  parameter int REGFILE_WIDTH      = 16,
  parameter int REGFILE_ADDR_WIDTH = 3,
  parameter int OPCODE_WIDTH       = 3
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  // instruction port
  input  logic                          Instr_Valid,
  output logic                          Instr_Ready,
  input  logic [OPCODE_WIDTH-1:0]       Instr_Opcode,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Rd,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Rs1,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Rs2,
  output logic                          Done,
  output logic                          Busy,
  // external load port
  input  logic                          Load_Req,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Load_Addr,
  input  logic [REGFILE_WIDTH-1:0]      Load_Data,
  output logic                          Load_Ack,
  // register file
  output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
  output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
  input  logic [REGFILE_WIDTH-1:0]      Data_Out_1,
  input  logic [REGFILE_WIDTH-1:0]      Data_Out_2,
  output logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr,
  output logic [REGFILE_WIDTH-1:0]      Data_In,
  output logic                          Write_enable,
  // ALU
  output logic [OPCODE_WIDTH-1:0]       ALU_Opcode,
  output logic [REGFILE_WIDTH-1:0]      ALU_A,
  output logic [REGFILE_WIDTH-1:0]      ALU_B,
  input  logic [REGFILE_WIDTH-1:0]      ALU_Result,
  // observation
  output logic [1:0]                    Dbg_State
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched instruction fields and datapath registers.
  logic [OPCODE_WIDTH-1:0]       opcode_q;
  logic [REGFILE_ADDR_WIDTH-1:0] rd_q;
  logic [REGFILE_ADDR_WIDTH-1:0] rs1_q;
  logic [REGFILE_ADDR_WIDTH-1:0] rs2_q;
  logic [REGFILE_WIDTH-1:0]      op_a_q;
  logic [REGFILE_WIDTH-1:0]      op_b_q;
  logic [REGFILE_WIDTH-1:0]      result_q;

  logic accept;
  logic load_grant;
  logic is_nop;

  assign is_nop = (opcode_q == '0);

  // An instruction is taken only in IDLE; outside IDLE Instr_* are ignored.
  assign accept = (state == IDLE) && Instr_Valid;

  // The write port belongs to the instruction in WB; otherwise a pending
  // load gets it. Gated by Reset_n so every output is 0 while in reset.
  assign load_grant = Reset_n && Load_Req && (state != WB);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = READ;
      READ: state_next = EXEC;
      // A NOP retires straight out of EXEC without touching the write port.
      EXEC: state_next = is_nop ? IDLE : WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction field latches: loaded only on acceptance, so they hold steady
  // for the whole instruction and keep the last values afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else if (accept) begin
      opcode_q <= Instr_Opcode;
      rd_q     <= Instr_Rd;
      rs1_q    <= Instr_Rs1;
      rs2_q    <= Instr_Rs2;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand latches. A load written at the same edge as the operand read
  // would be missed by the asynchronous read data, so its data is forwarded
  // into whichever operand(s) name the load address.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (state == READ) begin
      op_a_q <= (load_grant && (Load_Addr == rs1_q)) ? Load_Data : Data_Out_1;
      op_b_q <= (load_grant && (Load_Addr == rs2_q)) ? Load_Data : Data_Out_2;
    end
  end

  // Result register: captures the ALU output at the end of EXEC.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      result_q <= '0;
    end else if (state == EXEC) begin
      result_q <= ALU_Result;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    Instr_Ready  = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    Load_Ack     = 1'b0;
    Write_enable = 1'b0;
    Write_Addr   = '0;
    Data_In      = '0;
    if (Reset_n) begin
      Instr_Ready = (state == IDLE);
      Busy        = (state != IDLE);
      Done        = (state == WB) || ((state == EXEC) && is_nop);
      if (state == WB) begin
        Write_enable = 1'b1;
        Write_Addr   = rd_q;
        Data_In      = result_q;
      end else if (load_grant) begin
        Load_Ack     = 1'b1;
        Write_enable = 1'b1;
        Write_Addr   = Load_Addr;
        Data_In      = Load_Data;
      end
    end
  end

  // Read addresses and ALU operands come straight from the latches, so they
  // are valid in READ / EXEC and simply hold their last value elsewhere.
  assign Read_Addr_1 = rs1_q;
  assign Read_Addr_2 = rs2_q;
  assign ALU_Opcode  = opcode_q;
  assign ALU_A       = op_a_q;
  assign ALU_B       = op_b_q;
  assign Dbg_State   = state;

endmodule
